// File: rtl/demux_scheduler.sv
// Round-robin scheduler feeding a recurse_demux: one held word, one-hot sink valid, mask skips sinks.
// Optional per-sink bursting is enabled with `define DEMUX_SCHED_BURST_EN.
module demux_scheduler #(
  parameter int unsigned S     = 2,
  parameter int unsigned T     = 8,
  parameter int unsigned BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [T-1:0]      in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [(2**S)-1:0] mask,
  output logic [S-1:0]      ctrl,
  output logic [T-1:0]      data,
  output logic [(2**S)-1:0] out_valid,
  input  logic [(2**S)-1:0] out_ready
);

  localparam int unsigned N = 2**S;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t       state;
  logic         full;
  logic         any_en;
  logic         drain;
  logic         accept;
  logic [S-1:0] ptr;
  logic [S-1:0] sel;

  if (BURST < 1) begin : g_burst_chk
    $error("demux_scheduler: BURST must be >= 1");
  end

  // First enabled sink scanning cyclically from ptr; descending loop so the nearest wins.
  always_comb begin
    sel = ptr;
    for (int k = N - 1; k >= 0; k--) begin
      if (mask[ptr + S'(k)]) begin
        sel = ptr + S'(k);
      end
    end
  end

  assign full     = (state == FULL);
  assign any_en   = |mask;
  assign drain    = full & out_ready[ctrl];
  assign in_ready = any_en & (~full | drain);
  assign accept   = in_valid & in_ready;

  // Output register: a drain and an accept in the same cycle reload without a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      ctrl      <= '0;
      data      <= '0;
      out_valid <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state     <= FULL;
            ctrl      <= sel;
            data      <= in;
            out_valid <= N'(1) << sel;
          end
        end
        FULL: begin
          if (accept) begin
            ctrl      <= sel;
            data      <= in;
            out_valid <= N'(1) << sel;
          end else if (drain) begin
            state     <= EMPTY;
            out_valid <= '0;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= '0;
        end
      endcase
    end
  end

`ifdef DEMUX_SCHED_BURST_EN
  localparam int unsigned BCW = $clog2(BURST + 1);

  logic [BCW-1:0] bcnt;

  // Stay on a sink for BURST accepts; a skipped ptr lands on the chosen sink with one word counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr  <= '0;
      bcnt <= '0;
    end else if (accept) begin
      if ((sel == ptr) && (bcnt < BCW'(BURST - 1))) begin
        ptr  <= sel;
        bcnt <= bcnt + BCW'(1);
      end else if ((sel != ptr) && (BURST > 1)) begin
        ptr  <= sel;
        bcnt <= BCW'(1);
      end else begin
        ptr  <= sel + S'(1);
        bcnt <= '0;
      end
    end
  end
`else
  // Advance past the chosen sink on every accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= sel + S'(1);
    end
  end
`endif

endmodule

// File: tb/tb_demux_scheduler.sv
// Self-checking bench for demux_scheduler: directed scenarios plus a randomized run
// against a per-transaction reference model with per-sink ordering scoreboard.
module tb_demux_scheduler;

  localparam int S = 2;
  localparam int T = 8;
  localparam int N = 4;
`ifdef DEMUX_SCHED_BURST_EN
  localparam int BURST_M = 4;
`else
  localparam int BURST_M = 1;
`endif

  logic         clk;
  logic         rst;
  logic [T-1:0] in;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] mask;
  logic [S-1:0] ctrl;
  logic [T-1:0] data;
  logic [N-1:0] out_valid;
  logic [N-1:0] out_ready;

  int checks;
  int failures;

  demux_scheduler #(.S(S), .T(T), .BURST(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in       (in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mask     (mask),
    .ctrl     (ctrl),
    .data     (data),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    in       = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    mask      = 4'b1111;
    out_ready = 4'b1111;
    do_reset();
    #1;
    checks++; if (out_valid !== 4'b0000) begin failures++; $display("FAIL reset_out_valid got=%b exp=0000", out_valid); end
    checks++; if (ctrl !== 2'd0) begin failures++; $display("FAIL reset_ctrl got=%0d exp=0", ctrl); end
    checks++; if (data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", data); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_round_robin();
    do_reset();
    mask      = 4'b1111;
    out_ready = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      in       = 8'(i);
      in_valid = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rr_in_ready word=%0d got=%b exp=1", i, in_ready); end
      tick();
      checks++; if (ctrl !== 2'(i % 4)) begin failures++; $display("FAIL rr_ctrl word=%0d got=%0d exp=%0d", i, ctrl, i % 4); end
      checks++; if (data !== 8'(i)) begin failures++; $display("FAIL rr_data word=%0d got=%h exp=%h", i, data, 8'(i)); end
      checks++; if (out_valid !== 4'(1 << (i % 4))) begin failures++; $display("FAIL rr_out_valid word=%0d got=%b", i, out_valid); end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_mask_0101();
    logic [1:0] exp_c [4];
    logic [3:0] exp_v [4];
    exp_c = '{2'd0, 2'd2, 2'd0, 2'd2};
    exp_v = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
    do_reset();
    mask      = 4'b0101;
    out_ready = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      in       = 8'hA0 + 8'(i);
      in_valid = 1'b1;
      tick();
      checks++; if (ctrl !== exp_c[i]) begin failures++; $display("FAIL m0101_ctrl word=%0d got=%0d exp=%0d", i, ctrl, exp_c[i]); end
      checks++; if (out_valid !== exp_v[i]) begin failures++; $display("FAIL m0101_out_valid word=%0d got=%b exp=%b", i, out_valid, exp_v[i]); end
      checks++; if (data !== 8'hA0 + 8'(i)) begin failures++; $display("FAIL m0101_data word=%0d got=%h", i, data); end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    mask      = 4'b1111;
    out_ready = 4'b1101;
    in        = 8'h10;
    in_valid  = 1'b1;
    tick();
    in = 8'h11;
    tick();
    checks++; if (ctrl !== 2'd1) begin failures++; $display("FAIL bp_hold_ctrl got=%0d exp=1", ctrl); end
    in = 8'h12;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", c, in_ready); end
      checks++; if (out_valid !== 4'b0010) begin failures++; $display("FAIL bp_out_valid cyc=%0d got=%b exp=0010", c, out_valid); end
      checks++; if (data !== 8'h11) begin failures++; $display("FAIL bp_data cyc=%0d got=%h exp=11", c, data); end
      tick();
    end
    out_ready = 4'b1111;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_in_ready got=%b exp=1", in_ready); end
    tick();
    checks++; if (ctrl !== 2'd2) begin failures++; $display("FAIL bp_next_ctrl got=%0d exp=2", ctrl); end
    checks++; if (data !== 8'h12) begin failures++; $display("FAIL bp_next_data got=%h exp=12", data); end
    checks++; if (out_valid !== 4'b0100) begin failures++; $display("FAIL bp_next_out_valid got=%b exp=0100", out_valid); end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_mask_zero();
    do_reset();
    mask      = 4'b1111;
    out_ready = 4'b1111;
    in        = 8'h33;
    in_valid  = 1'b1;
    tick();
    mask = 4'b0000;
    in   = 8'h44;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL mz_in_ready cyc=%0d got=%b exp=0", c, in_ready); end
      tick();
      checks++; if (out_valid !== 4'b0000) begin failures++; $display("FAIL mz_out_valid cyc=%0d got=%b exp=0000", c, out_valid); end
    end
    mask = 4'b1000;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mz_reenable_in_ready got=%b exp=1", in_ready); end
    tick();
    checks++; if (ctrl !== 2'd3) begin failures++; $display("FAIL mz_ctrl got=%0d exp=3", ctrl); end
    checks++; if (data !== 8'h44) begin failures++; $display("FAIL mz_data got=%h exp=44", data); end
    checks++; if (out_valid !== 4'b1000) begin failures++; $display("FAIL mz_out_valid_after got=%b exp=1000", out_valid); end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_midop();
    do_reset();
    mask      = 4'b0100;
    out_ready = 4'b0000;
    in        = 8'h5A;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (ctrl !== 2'd2 || data !== 8'h5A) begin failures++; $display("FAIL rm_setup got ctrl=%0d data=%h exp ctrl=2 data=5a", ctrl, data); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (out_valid !== 4'b0000) begin failures++; $display("FAIL rm_out_valid got=%b exp=0000", out_valid); end
    checks++; if (ctrl !== 2'd0) begin failures++; $display("FAIL rm_ctrl got=%0d exp=0", ctrl); end
    checks++; if (data !== 8'h00) begin failures++; $display("FAIL rm_data got=%h exp=00", data); end
    mask      = 4'b1111;
    out_ready = 4'b1111;
    in        = 8'h77;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (ctrl !== 2'd0 || data !== 8'h77) begin failures++; $display("FAIL rm_next got ctrl=%0d data=%h exp ctrl=0 data=77", ctrl, data); end
    tick();
  endtask

`ifdef DEMUX_SCHED_BURST_EN
  task automatic test_burst();
    do_reset();
    mask      = 4'b1111;
    out_ready = 4'b1111;
    for (int i = 0; i < 12; i++) begin
      in       = 8'hC0 + 8'(i);
      in_valid = 1'b1;
      tick();
      checks++; if (ctrl !== 2'(i / 4)) begin failures++; $display("FAIL burst_ctrl word=%0d got=%0d exp=%0d", i, ctrl, i / 4); end
    end
    in_valid = 1'b0;
    tick();
  endtask
`endif

  // Random traffic against a transaction-level model: who is held, which sink is next, per-sink order.
  task automatic test_random();
    bit         m_full;
    int         m_ctrl;
    logic [7:0] m_data;
    int         m_ptr;
    int         m_cnt;
    int         sel;
    bit         drain;
    bit         exp_ir;
    logic [3:0] exp_ov;
    logic [7:0] sq [4][$];
    logic [7:0] want;

    do_reset();
    mask      = 4'b1111;
    out_ready = 4'b1111;
    m_full = 0; m_ctrl = 0; m_data = 0; m_ptr = 0; m_cnt = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      in        = 8'($urandom);
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) == 0) ? 4'b1111 : 4'($urandom);
      if ($urandom_range(15) == 0) mask = 4'($urandom);
      #1;
      exp_ov = m_full ? 4'(1 << m_ctrl) : 4'b0000;
      drain  = m_full && out_ready[m_ctrl];
      exp_ir = (mask != 4'b0000) && (!m_full || drain);
      checks++; if (in_ready !== exp_ir) begin failures++; $display("FAIL rnd_in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, exp_ir); end
      checks++; if (out_valid !== exp_ov) begin failures++; $display("FAIL rnd_out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, exp_ov); end
      checks++; if (ctrl !== 2'(m_ctrl) || data !== m_data) begin failures++; $display("FAIL rnd_held cyc=%0d got ctrl=%0d data=%h exp ctrl=%0d data=%h", cyc, ctrl, data, m_ctrl, m_data); end
      if (drain) begin
        want = (sq[m_ctrl].size() > 0) ? sq[m_ctrl].pop_front() : 8'hxx;
        checks++; if (data !== want) begin failures++; $display("FAIL rnd_sink_order cyc=%0d sink=%0d got=%h exp=%h", cyc, m_ctrl, data, want); end
      end
      if (exp_ir && in_valid) begin
        sel = -1;
        for (int k = 0; k < N; k++) begin
          if (sel < 0 && mask[(m_ptr + k) % N]) sel = (m_ptr + k) % N;
        end
        sq[sel].push_back(in);
        m_full = 1; m_ctrl = sel; m_data = in;
        m_cnt  = (sel == m_ptr) ? m_cnt + 1 : 1;
        if (m_cnt >= BURST_M) begin
          m_ptr = (sel + 1) % N;
          m_cnt = 0;
        end else begin
          m_ptr = sel;
        end
      end else if (drain) begin
        m_full = 0;
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    in        = '0;
    in_valid  = 1'b0;
    mask      = 4'b1111;
    out_ready = 4'b1111;
    test_reset();
    test_round_robin();
    test_mask_0101();
    test_backpressure();
    test_mask_zero();
    test_reset_midop();
`ifdef DEMUX_SCHED_BURST_EN
    test_burst();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
